// File: rtl/cache_line_arbiter.sv
// Two-port arbiter sharing one cache-line memory port between the I-cache (port 0) and D-cache (port 1).
// Define CACHE_ARB_RR_EN for round-robin tie-breaking; otherwise port 1 wins ties.
module cache_line_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic              c0_read,
    input  logic              c0_write,
    input  logic [LINE_W-1:0] c0_wdata,
    output logic [LINE_W-1:0] c0_rdata,
    output logic              c0_resp,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic              c1_read,
    input  logic              c1_write,
    input  logic [LINE_W-1:0] c1_wdata,
    output logic [LINE_W-1:0] c1_rdata,
    output logic              c1_resp,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    typedef enum logic [1:0] {IDLE, BUSY0, BUSY1, HOLD} state_t;

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                req0, req1, tie_pick1, grant1;

    assign req0 = c0_read | c0_write;
    assign req1 = c1_read | c1_write;

    // last_grant is tracked in both modes; fixed priority simply never lets it change the outcome
`ifdef CACHE_ARB_RR_EN
    assign tie_pick1 = ~last_grant_q;
`else
    assign tie_pick1 = last_grant_q | 1'b1;
`endif

    assign grant1 = req1 & (~req0 | tie_pick1);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (grant1) begin
                    mem_addr_d  = c1_addr;
                    mem_wdata_d = c1_wdata;
                    mem_write_d = c1_write;
                    mem_read_d  = c1_read & ~c1_write;
                    state_d     = BUSY1;
                end else if (req0) begin
                    mem_addr_d  = c0_addr;
                    mem_wdata_d = c0_wdata;
                    mem_write_d = c0_write;
                    mem_read_d  = c0_read & ~c0_write;
                    state_d     = BUSY0;
                end
            end
            BUSY0, BUSY1: begin
                if (mem_resp) begin
                    mem_read_d   = 1'b0;
                    mem_write_d  = 1'b0;
                    last_grant_d = (state_q == BUSY1);
                    state_d      = HOLD;
                end
            end
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Completion is combinational with mem_resp; rdata is gated so neither port sees the other's line
    assign c0_resp  = (state_q == BUSY0) & mem_resp;
    assign c1_resp  = (state_q == BUSY1) & mem_resp;
    assign c0_rdata = c0_resp ? mem_rdata : '0;
    assign c1_rdata = c1_resp ? mem_rdata : '0;

endmodule

// File: tb/tb_cache_line_arbiter.sv
// Scoreboard bench for cache_line_arbiter: expected memory transactions are queued as requests are driven
// and checked when the arbiter issues them and when the response is routed back.
module tb_cache_line_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] c0_addr, c1_addr, mem_addr;
    logic              c0_read, c0_write, c1_read, c1_write;
    logic [LINE_W-1:0] c0_wdata, c1_wdata, c0_rdata, c1_rdata;
    logic              c0_resp, c1_resp;
    logic              mem_read, mem_write, mem_resp;
    logic [LINE_W-1:0] mem_wdata, mem_rdata;

    typedef struct {
        bit                port;
        bit                is_write;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
        logic [LINE_W-1:0] rdata;
    } txn_t;

    txn_t exp_q[$];
    int   test_cnt = 0;
    int   fail_cnt = 0;
    bit   exp_last_grant = 1'b1;
    bit   rr_mode;

    cache_line_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .c0_addr(c0_addr), .c0_read(c0_read), .c0_write(c0_write), .c0_wdata(c0_wdata),
        .c0_rdata(c0_rdata), .c0_resp(c0_resp),
        .c1_addr(c1_addr), .c1_read(c1_read), .c1_write(c1_write), .c1_wdata(c1_wdata),
        .c1_rdata(c1_rdata), .c1_resp(c1_resp),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        test_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one requester and queues the memory transaction it should produce; call order = grant order
    task automatic applyStimulus(input bit port, input bit rd, input bit wr, input logic [ADDR_W-1:0] addr,
                                 input logic [LINE_W-1:0] wdata, input logic [LINE_W-1:0] rdata);
        txn_t t;
        if (port) begin
            c1_read = rd; c1_write = wr; c1_addr = addr; c1_wdata = wdata;
        end else begin
            c0_read = rd; c0_write = wr; c0_addr = addr; c0_wdata = wdata;
        end
        t.port = port; t.is_write = wr; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
        exp_q.push_back(t);
    endtask

    task automatic dropRequest(input bit port);
        if (port) begin
            c1_read = 1'b0; c1_write = 1'b0;
        end else begin
            c0_read = 1'b0; c0_write = 1'b0;
        end
    endtask

    // Plays the memory: waits for the next issued transaction, checks it, then returns the response
    task automatic serviceMem(input int latency, input int exp_wait, input bit hold_extra, input bit perturb);
        txn_t e;
        int   waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!(mem_read || mem_write) && waited < 30);
        if (!(mem_read || mem_write)) begin
            checkOutput("grant_timeout", 0, 1);
            return;
        end
        if (exp_q.size() == 0) begin
            checkOutput("scoreboard_empty", 0, 1);
            return;
        end
        e = exp_q.pop_front();
        if (exp_wait > 0) checkOutput("grant_latency", waited, exp_wait);
        checkOutput("mem_addr", mem_addr, e.addr);
        checkOutput("mem_read", mem_read, !e.is_write);
        checkOutput("mem_write", mem_write, e.is_write);
        if (e.is_write) checkOutput("mem_wdata", mem_wdata, e.wdata);
        checkOutput("early_resp", {c0_resp, c1_resp}, 2'b00);
        if (perturb) begin
            @(posedge clk); #1;
            if (e.port) c1_addr = 32'h80; else c0_addr = 32'h80;
        end
        for (int i = 1; i < latency; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("addr_hold", mem_addr, e.addr);
        end
        @(posedge clk); #1;
        mem_resp  = 1'b1;
        mem_rdata = e.rdata;
        @(negedge clk);
        checkOutput("resp_port", {c1_resp, c0_resp}, e.port ? 2'b10 : 2'b01);
        checkOutput("rdata_owner", e.port ? c1_rdata : c0_rdata, e.rdata);
        checkOutput("rdata_other", e.port ? c0_rdata : c1_rdata, '0);
        @(posedge clk); #1;
        mem_resp       = 1'b0;
        mem_rdata      = {8{32'hDEAD_BEEF}};
        exp_last_grant = e.port;
        if (!hold_extra) dropRequest(e.port);
        @(negedge clk);
        checkOutput("mem_drop", {mem_read, mem_write}, 2'b00);
        if (hold_extra) begin
            @(posedge clk); #1;
            dropRequest(e.port);
            @(negedge clk);
            @(negedge clk);
            checkOutput("no_reissue", {mem_read, mem_write}, 2'b00);
        end
    endtask

    initial begin
        txn_t tmp;
        int   waited;
        bit   first;
`ifdef CACHE_ARB_RR_EN
        rr_mode = 1'b1;
`else
        rr_mode = 1'b0;
`endif
        rst_n = 1'b0;
        c0_read = 0; c0_write = 0; c0_addr = '0; c0_wdata = '0;
        c1_read = 0; c1_write = 0; c1_addr = '0; c1_wdata = '0;
        mem_resp = 0; mem_rdata = {8{32'hDEAD_BEEF}};
        repeat (2) @(negedge clk);
        checkOutput("reset_mem", {mem_read, mem_write, c0_resp, c1_resp}, 4'b0000);
        checkOutput("reset_addr", mem_addr, '0);
        checkOutput("reset_wdata", mem_wdata, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Lone I-cache read
        @(posedge clk); #1;
        applyStimulus(0, 1, 0, 32'h0000_1000, '0, {32{8'hA5}});
        serviceMem(5, 2, 0, 0);

        // Lone D-cache write
        @(posedge clk); #1;
        applyStimulus(1, 0, 1, 32'h40, {8{32'h1234_5678}}, {8{32'h0F0F_0F0F}});
        serviceMem(3, 2, 0, 0);

        // Two ties in a row: round-robin alternates, fixed priority always picks port 1 first
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            first = rr_mode ? !exp_last_grant : 1'b1;
            applyStimulus(first, 1, 0, first ? 32'h200 : 32'h100, '0, {8{32'h1111_0000 + k}});
            applyStimulus(!first, 1, 0, first ? 32'h100 : 32'h200, '0, {8{32'h2222_0000 + k}});
            serviceMem(2, 2, 0, 0);
            serviceMem(4, 2, 0, 0);
        end

        // Requester keeps its read up one cycle past resp
        @(posedge clk); #1;
        applyStimulus(0, 1, 0, 32'h3000, '0, {8{32'hCAFE_F00D}});
        serviceMem(2, 2, 1, 0);

        // Address changes mid-transaction
        @(posedge clk); #1;
        applyStimulus(1, 0, 1, 32'h40, {8{32'h5555_AAAA}}, {8{32'h7777_7777}});
        serviceMem(4, 2, 0, 1);

        // Read and write together: the write wins
        @(posedge clk); #1;
        applyStimulus(0, 1, 1, 32'h500, {8{32'h9876_5432}}, {8{32'h3333_3333}});
        serviceMem(1, 2, 0, 0);

        // Stray mem_resp while idle
        @(posedge clk); #1;
        mem_resp = 1'b1;
        @(negedge clk);
        checkOutput("idle_resp", {c0_resp, c1_resp}, 2'b00);
        checkOutput("idle_rdata", c0_rdata | c1_rdata, '0);
        @(posedge clk); #1;
        mem_resp = 1'b0;

        // Async reset while the I-cache read is in flight
        @(posedge clk); #1;
        applyStimulus(0, 1, 0, 32'h2000, '0, {8{32'h4444_4444}});
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!mem_read && waited < 30);
        checkOutput("rst_test_grant", mem_read, 1'b1);
        tmp = exp_q.pop_front();
        checkOutput("rst_test_addr", mem_addr, tmp.addr);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_drop", {mem_read, mem_write}, 2'b00);
        checkOutput("rst_async_addr", mem_addr, '0);
        mem_resp = 1'b1;
        @(negedge clk);
        checkOutput("rst_resp_in_reset", {c0_resp, c1_resp}, 2'b00);
        @(posedge clk); #1;
        mem_resp = 1'b0;
        dropRequest(0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        mem_resp = 1'b1;
        @(negedge clk);
        checkOutput("rst_late_resp", {c0_resp, c1_resp, mem_read}, 3'b000);
        @(posedge clk); #1;
        mem_resp = 1'b0;
        @(negedge clk);

        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
